// File: rtl/npu_pkg.sv
// Shared definitions for the NPU datapath: image/window defaults and the
// window loader state encoding.
package npu_pkg;

  localparam int IMG_W_DEF      = 28;
  localparam int IMG_H_DEF      = 28;
  localparam int K_DEF          = 3;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/window_addr_gen.sv
// Walks a KxK window in raster order starting at a base address. It produces
// the image BRAM address and the element index, using only adders and
// counters.
module window_addr_gen
  import npu_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int K      = K_DEF,
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              last
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0]     POS_LAST   = CW'(K - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W - K + 1);

  logic [CW-1:0]     col;
  logic [CW-1:0]     row;
  logic              row_end;
  logic [ADDR_W-1:0] step;

  assign row_end = (col == POS_LAST);
  assign last    = row_end && (row == POS_LAST);
  // At the end of a window row, jump to the first column of the next image row.
  assign step    = row_end ? ROW_STRIDE : ADDR_W'(1);

  // Address, column/row and element counters: load on acceptance, then step once per fetch cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so that every flop samples pre-edge values.
    if (!rst_n) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
      idx  <= '0;
    end else if (load) begin
      addr <= base;
      col  <= '0;
      row  <= '0;
      idx  <= '0;
    end else if (advance) begin
      addr <= addr + step;
      idx  <= idx + 1'b1;
      if (row_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/window_loader.sv
// Fetches one KxK window of pixels from the image BRAM and writes it into
// one of two window register files (ping-pong), selected per request.
module window_loader
  import npu_pkg::*;
#(
  parameter int IMG_W           = IMG_W_DEF,
  parameter int IMG_H           = IMG_H_DEF,
  parameter int K               = K_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int WIN_ADDR_WIDTH  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_row,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_col,
  input  logic                       i_sel,
  output logic [BRAM_ADDR_WIDTH-1:0] o_bram_addr,
  input  logic [DATA_WIDTH-1:0]      i_bram_data,
  output logic                       o_win1_wr_en,
  output logic                       o_win2_wr_en,
  output logic [WIN_ADDR_WIDTH-1:0]  o_win_wr_addr,
  output logic [DATA_WIDTH-1:0]      o_win_wr_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err
);

  localparam logic [BRAM_ADDR_WIDTH-1:0] ROW_MAX = BRAM_ADDR_WIDTH'(IMG_H - K);
  localparam logic [BRAM_ADDR_WIDTH-1:0] COL_MAX = BRAM_ADDR_WIDTH'(IMG_W - K);
  localparam logic [BRAM_ADDR_WIDTH-1:0] IMG_W_A = BRAM_ADDR_WIDTH'(IMG_W);

  state_t                      state;
  state_t                      state_next;
  logic                        legal;
  logic                        accept;
  logic                        reject;
  logic                        advance;
  logic                        last;
  logic                        sel_q;
  logic [BRAM_ADDR_WIDTH-1:0]  base;
  logic [WIN_ADDR_WIDTH-1:0]   idx;

  assign legal = (i_row <= ROW_MAX) && (i_col <= COL_MAX);
  // The multiply happens once per request; per-element stepping is adder-only.
  assign base  = i_row * IMG_W_A + i_col;

  window_addr_gen #(
    .IMG_W  (IMG_W),
    .K      (K),
    .ADDR_W (BRAM_ADDR_WIDTH),
    .IDX_W  (WIN_ADDR_WIDTH)
  ) u_addr_gen (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .load    (accept),
    .advance (advance),
    .base    (base),
    .addr    (o_bram_addr),
    .idx     (idx),
    .last    (last)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          if (legal) begin
            accept     = 1'b1;
            state_next = FETCH;
          end else begin
            reject     = 1'b1;
          end
        end
      end
      FETCH: begin
        if (last) state_next = DRAIN;
        else      advance    = 1'b1;
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Buffer select, error pulse and write pipeline (one cycle behind the address).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sel_q         <= 1'b0;
      o_err         <= 1'b0;
      o_win1_wr_en  <= 1'b0;
      o_win2_wr_en  <= 1'b0;
      o_win_wr_addr <= '0;
    end else begin
      if (accept) sel_q <= i_sel;
      o_err         <= reject;
      o_win1_wr_en  <= (state == FETCH) && !sel_q;
      o_win2_wr_en  <= (state == FETCH) && sel_q;
      o_win_wr_addr <= (state == FETCH) ? idx : '0;
    end
  end

  // BRAM data arrives in the write cycle; it is zeroed when no strobe is active.
  assign o_win_wr_data = (o_win1_wr_en || o_win2_wr_en) ? i_bram_data : '0;
  assign o_busy        = (state == FETCH) || (state == DRAIN);
  assign o_done        = (state == DONE);

endmodule

// File: tb/tb_window_loader.sv
// Self-checking bench for window_loader: directed scenarios plus randomized
// window positions, checked cycle by cycle against a reference model.
module tb_window_loader;
  import npu_pkg::*;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 3;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int WW    = 4;
  localparam int NE    = K * K;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] row = '0;
  logic [AW-1:0] col = '0;
  logic          sel = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_q;
  logic          wr1;
  logic          wr2;
  logic [WW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          err;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  window_loader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DATA_WIDTH(DW),
    .BRAM_ADDR_WIDTH(AW), .WIN_ADDR_WIDTH(WW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_start      (start),
    .i_row        (row),
    .i_col        (col),
    .i_sel        (sel),
    .o_bram_addr  (bram_addr),
    .i_bram_data  (bram_q),
    .o_win1_wr_en (wr1),
    .o_win2_wr_en (wr2),
    .o_win_wr_addr(wr_addr),
    .o_win_wr_data(wr_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  // Synchronous-read BRAM model: data one cycle after the address.
  always @(posedge clk) bram_q <= mem[bram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Image address of window element e for a window whose top-left is (r, c).
  function automatic int elem_addr(input int r, input int c, input int e);
    return (r + e / K) * IMG_W + c + e % K;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".addr"},  32'(bram_addr), 0);
    check({tag, ".wr1"},   32'(wr1), 0);
    check({tag, ".wr2"},   32'(wr2), 0);
    check({tag, ".waddr"}, 32'(wr_addr), 0);
    check({tag, ".wdata"}, 32'(wr_data), 0);
    check({tag, ".busy"},  32'(busy), 0);
    check({tag, ".done"},  32'(done), 0);
    check({tag, ".err"},   32'(err), 0);
  endtask

  task automatic request(input int r, input int c, input bit s);
    start = 1'b1;
    row   = AW'(r);
    col   = AW'(c);
    sel   = s;
  endtask

  // Issue a request at a negedge and follow it cycle by cycle to o_done.
  // exp_wait: negedges until busy is first seen (2 when issued during DONE).
  task automatic fetch(input int r, input int c, input bit s, input int exp_wait, input bit inject);
    int    waited = 0;
    int    e;
    string t;
    request(r, c, s);
    do begin
      @(negedge clk);
      waited++;
    end while (!busy && waited < 4);
    check($sformatf("accept_wait(%0d,%0d)", r, c), 32'(waited), 32'(exp_wait));
    if (!busy) begin
      start = 1'b0;
      return;
    end
    for (int n = 0; n <= NE + 1; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0) start = 1'b0;
      if (inject && n == 3) request((r + 7) % (IMG_H - K + 1), (c + 5) % (IMG_W - K + 1), !s);
      if (n == NE + 1) start = 1'b0;
      t = $sformatf("win(%0d,%0d,s%0d)c%0d", r, c, s, n);
      check({t, ".busy"}, 32'(busy), 32'(n <= NE));
      check({t, ".done"}, 32'(done), 32'(n == NE + 1));
      check({t, ".err"},  32'(err), 0);
      if (n >= 1 && n <= NE) begin
        e = n - 1;
        check({t, ".wr1"},   32'(wr1), 32'(!s));
        check({t, ".wr2"},   32'(wr2), 32'(s));
        check({t, ".waddr"}, 32'(wr_addr), 32'(e));
        check({t, ".wdata"}, 32'(wr_data), 32'(mem[elem_addr(r, c, e)]));
      end else begin
        check({t, ".wr1"}, 32'(wr1), 0);
        check({t, ".wr2"}, 32'(wr2), 0);
      end
      if (n < NE) check({t, ".addr"}, 32'(bram_addr), 32'(elem_addr(r, c, n)));
    end
  endtask

  // Illegal request from IDLE: one-cycle o_err, no strobes, never busy.
  task automatic illegal(input int r, input int c);
    string t;
    t = $sformatf("illegal(%0d,%0d)", r, c);
    request(r, c, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check({t, ".err"},  32'(err), 1);
    check({t, ".busy"}, 32'(busy), 0);
    check({t, ".wr1"},  32'(wr1), 0);
    check({t, ".wr2"},  32'(wr2), 0);
    @(negedge clk);
    check({t, ".err_clr"}, 32'(err), 0);
    check({t, ".busy2"},   32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  r, c, waited;
    bit  prev_done;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i % 256);

    // Reset state.
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal fetch at the origin into window1.
    fetch(0, 0, 1'b0, 1, 1'b0);
    @(negedge clk);

    // Ping-pong: corner window into window2, then straight away into window1.
    fetch(IMG_W - K, IMG_H - K, 1'b1, 1, 1'b0);
    fetch(1, 2, 1'b0, 2, 1'b0);
    @(negedge clk);

    // Illegal positions.
    illegal(IMG_H - K + 1, 0);
    illegal(0, IMG_W - K + 1);

    // Start while busy with different row/col/sel is ignored.
    fetch(3, 4, 1'b0, 1, 1'b1);
    @(negedge clk);

    // Reset mid-fetch after the 4th write.
    request(5, 6, 1'b1);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!busy && waited < 4);
    check("rst_test.accept", 32'(busy), 1);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_test.wr2_before", 32'(wr2), 1);
    check("rst_test.idx_before", 32'(wr_addr), 3);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    repeat (2) begin
      @(negedge clk);
      check("rst_hold.done", 32'(done), 0);
      check("rst_hold.busy", 32'(busy), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    fetch(5, 6, 1'b1, 1, 1'b0);

    // Randomized positions over random image contents.
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    prev_done = 1'b1;
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, IMG_H - K + 1);
      c = $urandom_range(0, IMG_W - K + 1);
      if (r <= IMG_H - K && c <= IMG_W - K) begin
        if (prev_done && $urandom_range(0, 1) == 0) begin
          fetch(r, c, 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
        end else begin
          if (prev_done) @(negedge clk);
          fetch(r, c, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)));
        end
        prev_done = 1'b1;
      end else begin
        if (prev_done) @(negedge clk);
        illegal(r, c);
        prev_done = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/window_loader.md
WINDOW_LOADER -- requirements
Module: window_loader

Interface
REQ-001 Parameter IMG_W, default 28, image width in pixels.
REQ-002 Parameter IMG_H, default 28, image height in pixels.
REQ-003 Parameter K, default 3, window side (K*K elements).
REQ-004 Parameter DATA_WIDTH, default 8, pixel width.
REQ-005 Parameter BRAM_ADDR_WIDTH, default 10, image BRAM address width.
REQ-006 Parameter WIN_ADDR_WIDTH, default 4, window register address width.
REQ-007 The block SHALL have a single clock domain; reset is asynchronous and active-low.
REQ-008 Ports, in order:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-low.
- i_start  in  1  request one window fetch; sampled only in IDLE.
- i_row  in  BRAM_ADDR_WIDTH  top-left row of the window.
- i_col  in  BRAM_ADDR_WIDTH  top-left column of the window.
- i_sel  in  1  target buffer: 0 = window1, 1 = window2.
- o_bram_addr  out  BRAM_ADDR_WIDTH  image BRAM read address, registered.
- i_bram_data  in  DATA_WIDTH  BRAM read data, valid one cycle after the address.
- o_win1_wr_en  out  1  write strobe for window1.
- o_win2_wr_en  out  1  write strobe for window2.
- o_win_wr_addr  out  WIN_ADDR_WIDTH  element index 0..K*K-1.
- o_win_wr_data  out  DATA_WIDTH  pixel to write.
- o_busy  out  1  high from acceptance until o_done.
- o_done  out  1  one-cycle pulse when the window is complete.
- o_err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-009 The FSM SHALL have four states: IDLE, FETCH, DRAIN and DONE.
REQ-010 IDLE with i_start=1 and a legal position SHALL latch i_sel and the base address (i_row*IMG_W + i_col), load the element counter with 0, drive o_bram_addr = base, and go to FETCH.
REQ-011 A position is legal when i_row <= IMG_H-K and i_col <= IMG_W-K. On an illegal position the block SHALL pulse o_err for one cycle, issue no read and no write, and stay in IDLE.
REQ-012 FETCH SHALL advance o_bram_addr once per cycle in raster order:
- +1 within a window row.
- +(IMG_W-K+1) at the end of a window row.
- The per-element address update SHALL use no multiplier.
REQ-013 After the address for element K*K-1 has been issued, the FSM SHALL go to DRAIN for one cycle and then to DONE.
REQ-014 Each element read SHALL produce one write in the cycle after its address:
- o_win_wr_data = i_bram_data.
- o_win_wr_addr = element index (row*K + col).
- Only the strobe selected by the latched i_sel is high.
REQ-015 For K=3, exactly 9 writes SHALL occur, on consecutive cycles, with element indices 0..8 in order.
REQ-016 DONE SHALL pulse o_done for one cycle, drop o_busy in that same cycle, and return to IDLE. i_start is accepted again on the following edge.
REQ-017 Latency SHALL be fixed: o_done is high in the cycle after the (K*K+1)th rising edge following the accepting edge (10th edge for K=3).
REQ-018 i_start, i_row, i_col and i_sel SHALL be ignored while o_busy=1; a changing i_sel mid-fetch has no effect.
REQ-019 The two write strobes SHALL never be high in the same cycle. The strobes SHALL be low in IDLE and DONE.
REQ-020 A window at the maximum legal position (row = col = IMG_W-K, IMG_W = IMG_H) SHALL address up to IMG_W*IMG_H-1 with no wrap-around.

Reset
REQ-021 While i_rst=0, the block SHALL be in IDLE with all outputs 0, including o_bram_addr. Reset SHALL take effect immediately, without waiting for a clock edge.
REQ-022 Reset during FETCH or DRAIN SHALL abort the fetch with no o_done. Already-written window elements are left as-is. The first edge after release SHALL be treated as IDLE.

Structure
REQ-023 The shared package npu_pkg SHALL hold:
- The IMG_W, IMG_H, K and DATA_WIDTH defaults.
- The state enum {IDLE, FETCH, DRAIN, DONE}.
REQ-024 Address and element-index generation SHALL be one sub-module, window_addr_gen, containing the column/row counters and the stride adder. The FSM, write pipeline register and buffer select stay in window_loader.

Verification
REQ-025 Nominal fetch: BRAM[i] = i mod 256, start row=0 col=0 sel=0 -> window1 gets 0,1,2,28,29,30,56,57,58 at indices 0..8, no window2 strobe, o_done in the cycle after the 10th edge.
REQ-026 Ping-pong: row=25 col=25 sel=1, then immediately row=1 col=2 sel=0 -> window2 gets BRAM 725,726,727,753,754,755,781,782,783; window1 gets 30,31,32,58,59,60,86,87,88; back-to-back with one IDLE cycle between.
REQ-027 Illegal position: row=26 col=0 -> o_err pulses for one cycle, no strobes, o_busy stays 0.
REQ-028 Start while busy: second i_start asserted mid-fetch with different row/col/sel -> ignored, first window completes unchanged.
REQ-029 Reset mid-operation: i_rst low after the 4th write -> all outputs 0 immediately, no o_done; a new start after release completes normally.
